demux1x2x16_stream: RTL and testbench

//  Stream demultiplexer: the routing counterpart of the 2:1 word multiplexer. Accepts 16-bit words on one

---
 rtl/demux1x2x16_stream.sv | 144 ++++++++++++++
 tb/tb_demux1x2x16_stream.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2x16_stream.sv
// ---------------------------------------------------------------------------
// demux1x2x16_stream
//
// Purpose:
//   Stream demultiplexer. Takes words from one valid/ready producer and
//   steers each word into one of two buffered output channels, each backed
//   by its own small circular FIFO. With PACKET_MODE=1 the route is locked
//   from the first word of an in_last-framed burst until its last word, so
//   a whole packet lands on one channel. With PACKET_MODE=0 every word is
//   routed by its own in_sel and in_last is only carried along.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   in_data      input word (WIDTH bits)
//   in_sel       target channel, used only while the route is unlocked
//   in_last      last word of a packet, forwarded with the word
//   in_valid     input word present
//   in_ready     block can accept a word this cycle
//   outN_data    channel N head word (0 when channel empty)
//   outN_last    channel N head last flag (0 when channel empty)
//   outN_valid   channel N head valid
//   outN_ready   channel N consumer accepts head
//   outN_level   channel N FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module demux1x2x16_stream #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int PACKET_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out0_last,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic                     out1_last,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   out0_level,
  output logic [$clog2(DEPTH):0]   out1_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic [1:0]    r_state;
  // Each entry stores {last, data}.
  logic [WIDTH:0] r_mem   [2][DEPTH];
  logic [AW-1:0]  r_wptr  [2];
  logic [AW-1:0]  r_rptr  [2];
  logic [LW-1:0]  r_level [2];

  logic       w_route;
  logic       w_accept;
  logic [1:0] w_full;
  logic [1:0] w_valid;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_outReady;

  assign w_outReady = {out1_ready, out0_ready};

  // Route selection and handshakes. in_ready looks only at the state,
  // in_sel and the fill levels, never at in_valid, and a full FIFO refuses
  // a word even if its consumer drains that same cycle.
  always_comb begin
    w_route   = (r_state == ST_IDLE) ? in_sel : (r_state == ST_LOCK1);
    w_full[0] = (r_level[0] == LW'(DEPTH));
    w_full[1] = (r_level[1] == LW'(DEPTH));
    w_valid[0] = (r_level[0] != '0);
    w_valid[1] = (r_level[1] != '0);
    in_ready  = !w_full[w_route] && rst_n;
    w_accept  = in_valid && in_ready;
    w_push[0] = w_accept && !w_route;
    w_push[1] = w_accept && w_route;
    w_pop     = w_valid & w_outReady;
  end

  // Pointer and level bookkeeping. Pointers are AW bits wide, so with a
  // power-of-two DEPTH they wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_level[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_level[c] <= r_level[c] + 1'b1;
          2'b01:   r_level[c] <= r_level[c] - 1'b1;
          default: r_level[c] <= r_level[c];
        endcase
      end
    end
  end

  // Storage array carries no reset; stale contents are unreachable because
  // the read side is masked whenever a channel is empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_push[c]) r_mem[c][r_wptr[c]] <= {in_last, in_data};
    end
  end

  // Packet lock: the first non-last word of a burst pins the route until
  // the word carrying in_last has been accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (PACKET_MODE != 0 && w_accept) begin
      case (r_state)
        ST_IDLE:  r_state <= in_last ? ST_IDLE : (w_route ? ST_LOCK1 : ST_LOCK0);
        ST_LOCK0: r_state <= in_last ? ST_IDLE : ST_LOCK0;
        ST_LOCK1: r_state <= in_last ? ST_IDLE : ST_LOCK1;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_valid[0] ? r_mem[0][r_rptr[0]][WIDTH-1:0] : '0;
  assign out1_data  = w_valid[1] ? r_mem[1][r_rptr[1]][WIDTH-1:0] : '0;
  assign out0_last  = w_valid[0] && r_mem[0][r_rptr[0]][WIDTH];
  assign out1_last  = w_valid[1] && r_mem[1][r_rptr[1]][WIDTH];
  assign out0_level = r_level[0];
  assign out1_level = r_level[1];

endmodule

// File: tb/tb_demux1x2x16_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1x2x16_stream
//
// Purpose:
//   Self-checking bench for demux1x2x16_stream. Two instances share clock,
//   reset, input word fields and consumer readies: wDut runs per-word
//   routing (PACKET_MODE=0), pDut runs packet mode. Each has its own
//   in_valid. Expected words go into a per-channel queue when the bench sees
//   the input handshake, and a negedge monitor pops and compares whenever a
//   channel hands out a word.
// ---------------------------------------------------------------------------
module tb_demux1x2x16_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_last;
  logic        wIn_valid;
  logic        pIn_valid;
  logic        out0_ready;
  logic        out1_ready;

  logic        wIn_ready, pIn_ready;
  logic [15:0] wOut0_data, wOut1_data, pOut0_data, pOut1_data;
  logic        wOut0_last, wOut1_last, pOut0_last, pOut1_last;
  logic        wOut0_valid, wOut1_valid, pOut0_valid, pOut1_valid;
  logic [2:0]  wOut0_level, wOut1_level, pOut0_level, pOut1_level;

  int testsRun    = 0;
  int testsFailed = 0;

  // Expected {last, data} per channel: 0/1 = wDut ch0/ch1, 2/3 = pDut ch0/ch1.
  logic [16:0] expQ0[$];
  logic [16:0] expQ1[$];
  logic [16:0] expQ2[$];
  logic [16:0] expQ3[$];

  typedef struct {
    logic [15:0] data;
    logic        sel;
    logic        last;
    bit          expChan;
    bit          perWord;
  } vec_t;

  vec_t vecs[7];

  demux1x2x16_stream #(.WIDTH(16), .DEPTH(4), .PACKET_MODE(0)) wDut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(wIn_valid), .in_ready(wIn_ready),
    .out0_data(wOut0_data), .out0_last(wOut0_last),
    .out0_valid(wOut0_valid), .out0_ready(out0_ready),
    .out1_data(wOut1_data), .out1_last(wOut1_last),
    .out1_valid(wOut1_valid), .out1_ready(out1_ready),
    .out0_level(wOut0_level), .out1_level(wOut1_level)
  );

  demux1x2x16_stream #(.WIDTH(16), .DEPTH(4), .PACKET_MODE(1)) pDut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(pIn_valid), .in_ready(pIn_ready),
    .out0_data(pOut0_data), .out0_last(pOut0_last),
    .out0_valid(pOut0_valid), .out0_ready(out0_ready),
    .out1_data(pOut1_data), .out1_last(pOut1_last),
    .out1_valid(pOut1_valid), .out1_ready(out1_ready),
    .out0_level(pOut0_level), .out1_level(pOut1_level)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Current head of a channel as {valid, last, data}.
  function automatic logic [17:0] headOf(input int idx);
    case (idx)
      0:       return {wOut0_valid, wOut0_last, wOut0_data};
      1:       return {wOut1_valid, wOut1_last, wOut1_data};
      2:       return {pOut0_valid, pOut0_last, pOut0_data};
      default: return {pOut1_valid, pOut1_last, pOut1_data};
    endcase
  endfunction

  task automatic pushExpected(input int idx, input logic [16:0] val);
    case (idx)
      0:       expQ0.push_back(val);
      1:       expQ1.push_back(val);
      2:       expQ2.push_back(val);
      default: expQ3.push_back(val);
    endcase
  endtask

  task automatic popExpected(input int idx, output bit ok, output logic [16:0] val);
    ok  = 1'b0;
    val = '0;
    case (idx)
      0: if (expQ0.size() > 0) begin ok = 1'b1; val = expQ0.pop_front(); end
      1: if (expQ1.size() > 0) begin ok = 1'b1; val = expQ1.pop_front(); end
      2: if (expQ2.size() > 0) begin ok = 1'b1; val = expQ2.pop_front(); end
      default: if (expQ3.size() > 0) begin ok = 1'b1; val = expQ3.pop_front(); end
    endcase
  endtask

  // Output monitor: any word handed to a consumer must match the oldest
  // expected word for that channel, last flag included.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int idx = 0; idx < 4; idx++) begin
        logic [17:0] head;
        logic        rdy;
        bit          ok;
        logic [16:0] exp;
        head = headOf(idx);
        rdy  = (idx % 2 == 0) ? out0_ready : out1_ready;
        if (head[17] && rdy) begin
          popExpected(idx, ok, exp);
          if (!ok) checkOutput($sformatf("unexpectedWord ch%0d", idx), {15'd0, head[16:0]}, 32'hFFFF_FFFF);
          else     checkOutput($sformatf("outWord ch%0d", idx), {15'd0, head[16:0]}, {15'd0, exp});
        end
      end
    end
  end

  // Drive one word into the chosen instance, wait (bounded) for in_ready,
  // queue the expected result, and return 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [15:0] data, input logic sel,
                               input logic last, input bit expChan,
                               input bit perWord);
    int waitCycles = 0;
    bit accepted   = 1'b0;
    in_data = data;
    in_sel  = sel;
    in_last = last;
    if (perWord) wIn_valid = 1'b1;
    else         pIn_valid = 1'b1;
    while (!accepted && waitCycles < 20) begin
      @(negedge clk);
      if (perWord ? wIn_ready : pIn_ready) accepted = 1'b1;
      else                                 waitCycles++;
    end
    if (accepted) pushExpected((perWord ? 0 : 2) + int'(expChan), {last, data});
    else          checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    wIn_valid = 1'b0;
    pIn_valid = 1'b0;
  endtask

  // Bounded wait until every expected word has come out.
  task automatic waitDrain();
    int left;
    for (int i = 0; i < 40; i++) begin
      left = expQ0.size() + expQ1.size() + expQ2.size() + expQ3.size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    left = expQ0.size() + expQ1.size() + expQ2.size() + expQ3.size();
    checkOutput("drainQueues", left, 32'd0);
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, table vectors, then the multi-cycle corner cases.
  initial begin
    // Per-word routing on wDut (last=0 must not lock), then packet lock on pDut.
    vecs[0] = '{16'h1111, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h2222, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{16'h3333, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'hA000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hA001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'hA002, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'hA003, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_last    = 1'b0;
    wIn_valid  = 1'b0;
    pIn_valid  = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // Reset for two cycles; in_ready must be low while reset is held.
    @(posedge clk);
    #1;
    checkOutput("inReadyDuringReset", pIn_ready, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("resetInReady",   {wIn_ready, pIn_ready}, 32'h3);
    checkOutput("resetValids",    {wOut0_valid, wOut1_valid, pOut0_valid, pOut1_valid}, 32'h0);
    checkOutput("resetLevels",    {wOut0_level, wOut1_level, pOut0_level, pOut1_level}, 32'h0);
    checkOutput("resetOut0Data",  pOut0_data, 32'h0);
    checkOutput("resetOut1Last",  pOut1_last, 32'h0);
    @(posedge clk);
    #1;

    // Table vectors with a one-cycle latency check on each accepted word.
    for (int i = 0; i < 7; i++) begin
      int idx;
      idx = (vecs[i].perWord ? 0 : 2) + int'(vecs[i].expChan);
      applyStimulus(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].expChan, vecs[i].perWord);
      checkOutput($sformatf("latency vec%0d", i), headOf(idx), {1'b1, vecs[i].last, vecs[i].data});
    end
    waitDrain();

    // Fill channel 0 while its consumer stalls; channel 1 keeps flowing.
    out0_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(16'hC000 + 16'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fullLevel", pOut0_level, 32'd4);
    in_sel = 1'b0;
    #1;
    checkOutput("fullReadySel0", pIn_ready, 32'd0);
    in_sel = 1'b1;
    #1;
    checkOutput("fullReadySel1", pIn_ready, 32'd1);
    in_sel = 1'b0;
    out0_ready = 1'b1;
    #1;
    checkOutput("noPassThrough", pIn_ready, 32'd0);
    out0_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("otherChanFlows", headOf(3), {2'b11, 16'hBEEF});
    checkOutput("stalledHeadHeld", headOf(2), {2'b11, 16'hC000});
    checkOutput("stalledLevelHeld", pOut0_level, 32'd4);
    out0_ready = 1'b1;
    waitDrain();

    // Push and pop in the same cycle at level 2: level stays 2.
    out0_ready = 1'b0;
    applyStimulus(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pushPopStart", pOut0_level, 32'd2);
    out0_ready = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(16'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("pushPopLevel%0d", i), pOut0_level, 32'd2);
    end
    waitDrain();

    // Reset in the middle of a packet locked to channel 0.
    out0_ready = 1'b0;
    applyStimulus(16'hD000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hD001, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lockedLevels", {pOut0_level, pOut1_level}, {26'd0, 3'd2, 3'd0});
    rst_n = 1'b0;
    expQ2.delete();
    @(posedge clk);
    #1;
    checkOutput("midResetLevel", pOut0_level, 32'd0);
    checkOutput("midResetValid", pOut0_valid, 32'd0);
    rst_n = 1'b1;
    out0_ready = 1'b1;
    #1;
    applyStimulus(16'hE000, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("postResetRoute", headOf(3), {2'b11, 16'hE000});
    checkOutput("postResetCh0Empty", pOut0_valid, 32'd0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
